mfcc_frame_streamer: RTL
========================

// Module: mfcc_frame_streamer
// PURPOSE
//  Upstream feeder for the LSTM datapath. Buffers MFCC coefficients from the feature extractor in a circular
//  frame buffer. On each rising edge of the LSTM's w_x_en request, streams one complete INPUT_SIZE-word frame
//  (f_in_valid/feature_in). Counts frames delivered and flags end of the TIME_STEP-frame utterance.
// PARAMETERS
//  INPUT_SIZE   26   words per frame (MFCC coefficients per timestep)
//  TIME_STEP    148  frames per utterance
//  NUM_FRAMES   4    frame slots in buffer; DEPTH = NUM_FRAMES*INPUT_SIZE words
//  D_WL         24   data word width (Q(D_WL-FL).FL, passed through untouched)
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     reset, asynchronous, active-low
//  seq_restart  in   1     sync pulse: flush buffer, clear counters, go IDLE
//  mfcc_valid   in   1     upstream word valid
//  mfcc_data    in   D_WL  upstream MFCC word
//  mfcc_ready   out  1     buffer can accept a word (= stored_words < DEPTH)
//  w_x_en       in   1     LSTM frame request; rising edge = request one frame
//  f_in_valid   out  1     feature_in valid, high for exactly INPUT_SIZE consecutive cycles per frame
//  feature_in   out  D_WL  frame word, coefficient 0 first
//  frame_idx    out  8     frames delivered this utterance (0..TIME_STEP)
//  seq_done     out  1     level: TIME_STEP frames delivered
//  err_underrun out  1     sticky: w_x_en fell while a request was still unserved
// BEHAVIOUR
//  Reset: f_in_valid=0, feature_in=0, frame_idx=0, seq_done=0, err_underrun=0; pointers/counters=0.
//   mfcc_ready is combinational and reads 1 during and after reset.
//  Write: when mfcc_valid&&mfcc_ready, store at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
//   stored_words increments on write. Every INPUT_SIZE-th write completes a frame: frames_avail++.
//  Request detection: req = w_x_en & ~w_x_en_q (w_x_en_q is a registered copy). A level-high w_x_en never
//   retriggers. A request in STREAM or DONE is ignored.
//  FSM
//   IDLE:      on req, go to STREAM if frames_avail>0, else go to WAIT_DATA.
//   WAIT_DATA: go to STREAM on the first cycle frames_avail>0.
//              If w_x_en==0 first, set err_underrun and go to IDLE (request dropped).
//   STREAM:    word counter k=0..INPUT_SIZE-1; f_in_valid=1, feature_in=buf[rd_ptr] (registered outputs).
//              rd_ptr wraps like wr_ptr. After word INPUT_SIZE-1: frames_avail--, stored_words-=INPUT_SIZE,
//              frame_idx++. Go to DONE if frame_idx reaches TIME_STEP, else go to IDLE.
//              w_x_en falling mid-frame does not abort the frame.
//   DONE:      seq_done=1. Ignore requests. Writes still accepted. Leave only via seq_restart.
//  Latency: req sampled at edge N with a frame available -> first word valid after edge N+1.
//   Last word after edge N+INPUT_SIZE. f_in_valid=0, feature_in=0 on the following edge.
//  Simultaneous: a write that completes a frame in the same cycle as a STREAM last-word read leaves
//   frames_avail unchanged. The write counts for the WAIT_DATA exit on the next cycle (registered count).
//  Full: stored_words==DEPTH -> mfcc_ready=0. The same-cycle final read does not raise ready
//   until the next cycle.
//  seq_restart: has priority over all other activity. Clears pointers, counts, frame_idx, seq_done,
//   err_underrun, f_in_valid, feature_in. A write in the same cycle is discarded.
//  Reset mid-frame: outputs clear immediately (async). Any partial frame is lost.
// TESTING
//  1. Write 26 words 0x000001..0x00001A, pulse w_x_en -> f_in_valid for 26 cycles starting 1 cycle after
//     the edge; feature_in 0x000001..0x00001A in order; frame_idx=1.
//  2. w_x_en rises with buffer empty, then 26 words are written -> stream starts the cycle after
//     frames_avail=1, err_underrun=0.
//  3. w_x_en rises with buffer empty, then falls after 5 cycles with no data -> err_underrun=1,
//     FSM IDLE, no f_in_valid.
//  4. Write 104 words with no requests -> mfcc_ready=0 on the cycle after the 104th write.
//     Stream one frame -> mfcc_ready=1 after the last word. The 105th word lands at address 0 (wrap).
//  5. Feed 148 frames with 148 requests -> seq_done=1, frame_idx=148; a 149th w_x_en edge gives no
//     f_in_valid. seq_restart -> frame_idx=0, seq_done=0.
//  6. Assert rst_n=0 at word 10 of a stream -> f_in_valid=0 and feature_in=0 immediately; mfcc_ready=1.

Source files
------------

// File: rtl/mfcc_frame_streamer_if.sv
// Handshake/bus bundle between the MFCC frame streamer and its neighbours:
// upstream word feed from the feature extractor, downstream frame stream to the LSTM.
interface mfcc_frame_streamer_if #(
    parameter int unsigned D_WL = 24
) ();
    logic              mfcc_valid;
    logic [D_WL-1:0]   mfcc_data;
    logic              mfcc_ready;
    logic              w_x_en;
    logic              f_in_valid;
    logic [D_WL-1:0]   feature_in;

    // Streamer side
    modport master (
        input  mfcc_valid,
        input  mfcc_data,
        input  w_x_en,
        output mfcc_ready,
        output f_in_valid,
        output feature_in
    );

    // Environment side (feature extractor + LSTM)
    modport slave (
        output mfcc_valid,
        output mfcc_data,
        output w_x_en,
        input  mfcc_ready,
        input  f_in_valid,
        input  feature_in
    );
endinterface

// File: rtl/mfcc_frame_streamer.sv
// Circular frame buffer for MFCC words; streams one INPUT_SIZE-word frame to the
// LSTM per rising edge of w_x_en and tracks utterance progress.
module mfcc_frame_streamer #(
    parameter int unsigned INPUT_SIZE = 26,
    parameter int unsigned TIME_STEP  = 148,
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned D_WL       = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   seq_restart,
    mfcc_frame_streamer_if.master  bus,
    output logic [7:0]             frame_idx,
    output logic                   seq_done,
    output logic                   err_underrun
);
    localparam int unsigned DEPTH = NUM_FRAMES * INPUT_SIZE;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SW    = $clog2(DEPTH + 1);
    localparam int unsigned FW    = $clog2(NUM_FRAMES + 1);
    localparam int unsigned KW    = $clog2(INPUT_SIZE);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, STREAM, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [KW-1:0]     wcnt_q, wcnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [SW-1:0]     stored_q, stored_d;
    logic [FW-1:0]     frames_q, frames_d;
    logic [7:0]        frame_idx_q, frame_idx_d;
    logic              seq_done_q, seq_done_d;
    logic              err_q, err_d;
    logic              f_in_valid_q, f_in_valid_d;
    logic [D_WL-1:0]   feature_in_q, feature_in_d;
    logic              w_x_en_q, w_x_en_d;
    logic [D_WL-1:0]   mem_q [DEPTH];

    logic              ready;
    logic              wr_en;
    logic              req;
    logic              wr_frame_done;
    logic              rd_frame_done;

    assign ready = (stored_q < SW'(DEPTH));
    // A restart discards any write presented in the same cycle
    assign wr_en = bus.mfcc_valid && ready && !seq_restart;
    assign req   = bus.w_x_en && !w_x_en_q;

    assign bus.mfcc_ready = ready;
    assign bus.f_in_valid = f_in_valid_q;
    assign bus.feature_in = feature_in_q;
    assign frame_idx      = frame_idx_q;
    assign seq_done       = seq_done_q;
    assign err_underrun   = err_q;

    // Word storage; contents need no reset because counts gate every read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.mfcc_data;
        end
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wcnt_q       <= '0;
            k_q          <= '0;
            stored_q     <= '0;
            frames_q     <= '0;
            frame_idx_q  <= '0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
            f_in_valid_q <= 1'b0;
            feature_in_q <= '0;
            w_x_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wcnt_q       <= wcnt_d;
            k_q          <= k_d;
            stored_q     <= stored_d;
            frames_q     <= frames_d;
            frame_idx_q  <= frame_idx_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
            f_in_valid_q <= f_in_valid_d;
            feature_in_q <= feature_in_d;
            w_x_en_q     <= w_x_en_d;
        end
    end

    // Next-state: write bookkeeping, request FSM, frame streaming, restart override
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wcnt_d        = wcnt_q;
        k_d           = k_q;
        stored_d      = stored_q;
        frames_d      = frames_q;
        frame_idx_d   = frame_idx_q;
        seq_done_d    = seq_done_q;
        err_d         = err_q;
        f_in_valid_d  = 1'b0;
        feature_in_d  = '0;
        w_x_en_d      = bus.w_x_en;
        wr_frame_done = 1'b0;
        rd_frame_done = 1'b0;

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (wcnt_q == KW'(INPUT_SIZE - 1)) begin
                wcnt_d        = '0;
                wr_frame_done = 1'b1;
            end else begin
                wcnt_d = wcnt_q + KW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = (frames_q != '0) ? STREAM : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (frames_q != '0) begin
                    state_d = STREAM;
                end else if (!bus.w_x_en) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                f_in_valid_d = 1'b1;
                feature_in_d = mem_q[rd_ptr_q];
                rd_ptr_d     = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
                if (k_q == KW'(INPUT_SIZE - 1)) begin
                    k_d           = '0;
                    rd_frame_done = 1'b1;
                    frame_idx_d   = frame_idx_q + 8'd1;
                    if (frame_idx_q == 8'(TIME_STEP - 1)) begin
                        state_d    = DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                seq_done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A frame completed and a frame consumed in one cycle cancel out
        if (wr_frame_done && !rd_frame_done) begin
            frames_d = frames_q + FW'(1);
        end else if (rd_frame_done && !wr_frame_done) begin
            frames_d = frames_q - FW'(1);
        end
        stored_d = stored_q + SW'(wr_en) - (rd_frame_done ? SW'(INPUT_SIZE) : SW'(0));

        if (seq_restart) begin
            state_d      = IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            wcnt_d       = '0;
            k_d          = '0;
            stored_d     = '0;
            frames_d     = '0;
            frame_idx_d  = '0;
            seq_done_d   = 1'b0;
            err_d        = 1'b0;
            f_in_valid_d = 1'b0;
            feature_in_d = '0;
        end
    end
endmodule
